vae_latent_encoder: RTL

//  Encoder half of the on-board VAE. It consumes one 14x14 image (196 signed pixels) as a valid/ready stream.
//  It computes the 2 latent values with a single linear layer: z[j] = sat(((sum_i x[i]*W[j][i]) + (B[j]<<FRAC)) >>> FRAC).
//  Its output matches the decoder's 2-entry signed 10-bit latent input, so an image can be round-tripped through the VGA path.
//  It uses one time-shared MAC per latent, one pixel per accepted beat, and a level finish flag.

---
 rtl/vae_pkg.sv | 57 +++++
 rtl/enc_weight_rom.sv | 42 ++++
 rtl/vae_latent_encoder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/vae_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vae_pkg
// Description : Shared types, sizes and saturation helper for the on-board VAE
//               (latent encoder and decoder).
//               Contents: pixel/latent widths, weight width, accumulator width,
//               latent vector typedef, encoder FSM state enum, default weight
//               image, sat_signed() clamp.
// Revision    : 1.0 - initial release
// ============================================================================
package vae_pkg;

    localparam int N_PIX    = 196;                    // pixels per 14x14 image
    localparam int DATA_W   = 10;                     // signed pixel / latent width
    localparam int W_W      = 8;                      // signed weight / bias width
    localparam int ACC_W    = 26;                     // signed accumulator width
    localparam int N_LATENT = 2;
    localparam int CNT_W    = $clog2(N_PIX + 1);      // holds 0..N_PIX inclusive
    localparam int PROD_W   = DATA_W + W_W;
    localparam int ROM_W    = N_LATENT * W_W;         // {W[1][i], W[0][i]}

    // Flat weight image: element k sits at bits [k*W_W +: W_W].
    // k = 0..N_PIX-1 -> W[0][k], k = N_PIX..2*N_PIX-1 -> W[1][k-N_PIX],
    // k = 2*N_PIX -> B[0], k = 2*N_PIX+1 -> B[1].
    localparam int WINIT_W = (2 * N_PIX + 2) * W_W;

    // Unity weights (64 = 1.0 with 6 fraction bits), zero biases.
    localparam logic [WINIT_W-1:0] WEIGHT_DEFAULT =
        {{(2 * W_W){1'b0}}, {(2 * N_PIX){W_W'(64)}}};

    typedef logic signed [DATA_W-1:0] latent_t;
    typedef latent_t [N_LATENT-1:0]   latent_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_BIAS  = 3'd3,
        ST_DONE  = 3'd4
    } enc_state_e;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    // Clamp a full-width accumulator value into the signed latent range.
    function automatic latent_t sat_signed(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (v < SAT_MIN) begin
            return {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_weight_rom.sv
`default_nettype none
// ============================================================================
// Module      : enc_weight_rom
// Description : Encoder weight ROM, synchronous read with 1-cycle latency.
//               Address i (0..N_PIX-1) returns {W[1][i], W[0][i]};
//               address N_PIX returns the bias pair {B[1], B[0]}.
// Ports       : clk     - system clock
//               addr_i  - word address
//               w0_o    - latent-0 coefficient (signed W_W)
//               w1_o    - latent-1 coefficient (signed W_W)
// Revision    : 1.0 - initial release
// ============================================================================
module enc_weight_rom
    import vae_pkg::*;
#(
    parameter logic [WINIT_W-1:0] WEIGHT_INIT = WEIGHT_DEFAULT
) (
    input  logic                  clk,
    input  logic [CNT_W-1:0]      addr_i,
    output logic signed [W_W-1:0] w0_o,
    output logic signed [W_W-1:0] w1_o
);

    logic [ROM_W-1:0] rom [N_PIX + 1];
    logic [ROM_W-1:0] word_q;

    for (genvar a = 0; a < N_PIX; a++) begin : g_word
        assign rom[a] = {WEIGHT_INIT[(N_PIX + a) * W_W +: W_W],
                         WEIGHT_INIT[a * W_W +: W_W]};
    end

    assign rom[N_PIX] = {WEIGHT_INIT[(2 * N_PIX + 1) * W_W +: W_W],
                         WEIGHT_INIT[(2 * N_PIX) * W_W +: W_W]};

    always_ff @(posedge clk) begin
        word_q <= rom[addr_i];
    end

    assign {w1_o, w0_o} = word_q;

endmodule
`default_nettype wire

// File: rtl/vae_latent_encoder.sv
`default_nettype none
// ============================================================================
// Module      : vae_latent_encoder
// Description : VAE encoder linear layer. Streams one 196-pixel image and
//               produces two saturated signed latents
//               z[j] = sat(((sum x[i]*W[j][i]) + (B[j] << FRAC)) >>> FRAC).
// Ports       : clk            - system clock
//               rst_n          - asynchronous active-low reset
//               enable_i       - rising edge starts an encode
//               pix_valid_i    - pixel stream valid
//               pix_ready_o    - pixel stream ready
//               pix_data_i     - signed pixel, row-major, index 0 first
//               latent_node_o  - {z[1], z[0]}
//               finish_o       - result valid, no encode in progress
// Revision    : 1.0 - initial release
// ============================================================================
module vae_latent_encoder
    import vae_pkg::*;
#(
    parameter int                 FRAC        = 6,
    parameter logic [WINIT_W-1:0] WEIGHT_INIT = WEIGHT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic                     pix_valid_i,
    output logic                     pix_ready_o,
    input  logic [DATA_W-1:0]        pix_data_i,
    output logic [2*DATA_W-1:0]      latent_node_o,
    output logic                     finish_o
);

    enc_state_e               state_q, state_d;
    logic                     enable_q;
    logic [CNT_W-1:0]         cnt_q;
    latent_t                  pix_q;
    logic                     mac_vld_q;
    logic signed [ACC_W-1:0]  acc_q [N_LATENT];
    latent_vec_t              latent_q;
    logic                     finish_q;

    logic signed [W_W-1:0]    coef [N_LATENT];
    logic signed [ACC_W-1:0]  prod_ext [N_LATENT];
    logic signed [ACC_W-1:0]  acc_bias [N_LATENT];
    latent_vec_t              latent_nxt;

    logic start;
    logic accept;
    logic last_beat;

    assign start     = enable_i && !enable_q &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept    = pix_valid_i && (state_q == ST_RUN);
    assign last_beat = accept && (cnt_q == CNT_W'(N_PIX - 1));

    // The count stops at N_PIX after the last beat, which is also the bias
    // word address, so the bias pair is already being read during DRAIN.
    enc_weight_rom #(
        .WEIGHT_INIT (WEIGHT_INIT)
    ) u_rom (
        .clk    (clk),
        .addr_i (cnt_q),
        .w0_o   (coef[0]),
        .w1_o   (coef[1])
    );

    for (genvar j = 0; j < N_LATENT; j++) begin : g_lane
        logic signed [PROD_W-1:0] prod;
        logic signed [ACC_W-1:0]  bias_ext;
        logic signed [ACC_W-1:0]  acc_shift;

        assign prod        = pix_q * coef[j];
        assign prod_ext[j] = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        // In BIAS the ROM presents B[j]; align it with the integer part.
        assign bias_ext    = {{(ACC_W - W_W - FRAC){coef[j][W_W-1]}}, coef[j],
                              {FRAC{1'b0}}};
        assign acc_bias[j] = acc_q[j] + bias_ext;
        assign acc_shift   = acc_bias[j] >>> FRAC;
        assign latent_nxt[j] = sat_signed(acc_shift);
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
            ST_RUN:           if (last_beat) state_d = ST_DRAIN;
            ST_DRAIN:         state_d = ST_BIAS;
            ST_BIAS:          state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q  <= 1'b0;
            cnt_q     <= '0;
            pix_q     <= '0;
            mac_vld_q <= 1'b0;
            latent_q  <= '0;
            finish_q  <= 1'b0;
            for (int j = 0; j < N_LATENT; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            enable_q  <= enable_i;
            mac_vld_q <= accept;

            if (start) begin
                cnt_q    <= '0;
                finish_q <= 1'b0;
                for (int j = 0; j < N_LATENT; j++) begin
                    acc_q[j] <= '0;
                end
            end

            if (accept) begin
                cnt_q <= cnt_q + 1'b1;
                pix_q <= pix_data_i;
            end

            // Pixel registered last cycle meets its weight from the ROM now.
            if (mac_vld_q) begin
                for (int j = 0; j < N_LATENT; j++) begin
                    acc_q[j] <= acc_q[j] + prod_ext[j];
                end
            end

            if (state_q == ST_BIAS) begin
                for (int j = 0; j < N_LATENT; j++) begin
                    acc_q[j] <= acc_bias[j];
                end
                latent_q <= latent_nxt;
                finish_q <= 1'b1;
            end
        end
    end

    assign pix_ready_o   = (state_q == ST_RUN);
    assign latent_node_o = latent_q;
    assign finish_o      = finish_q;

endmodule
`default_nettype wire
